// File: rtl/rpc_rd_buf_pkg.sv
// Shared types and sizing helpers for the RPC DRAM read-buffer scheduler.
package rpc_rd_buf_pkg;

    localparam int unsigned DefDramLenWidth   = 6;
    localparam int unsigned DefBufferDepth    = 4;
    localparam int unsigned DefMaxOutstanding = 4;
    localparam int unsigned DefDramAddrWidth  = 24;

    // Scheduler states: accept a request, wait for buffer credit, present the command.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ISSUE = 2'd2
    } state_e;

    typedef logic [DefDramLenWidth-1:0] len_t;

    // Buffer capacity in words: a number of maximum-length bursts.
    function automatic int unsigned num_words(input int unsigned depth, input int unsigned len_width);
        return depth << len_width;
    endfunction

    // Credit arithmetic needs one bit above the usage width plus a sign bit.
    function automatic int unsigned credit_width(input int unsigned depth, input int unsigned len_width);
        return $clog2(num_words(depth, len_width)) + 2;
    endfunction

endpackage

// File: rtl/fifo_v3.sv
// Small synchronous FIFO holding the lengths of bursts that are in flight.
// Pushes while full and pops while empty are ignored.
module fifo_v3 #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    output logic                  full_o,
    output logic                  empty_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  pop_i
);

    localparam int unsigned        PtrWidth  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PtrWidth-1:0] LastPtr  = PtrWidth'(DEPTH - 1);
    localparam logic [PtrWidth:0]  FullCount = (PtrWidth + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [PtrWidth-1:0]   rd_ptr_r;
    logic [PtrWidth-1:0]   wr_ptr_r;
    logic [PtrWidth:0]     count_r;
    logic                  push_s;
    logic                  pop_s;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] ptr);
        logic [PtrWidth-1:0] nxt;
        if (ptr == LastPtr) begin
            nxt = '0;
        end else begin
            nxt = ptr + PtrWidth'(1);
        end
        return nxt;
    endfunction

    assign full_o  = (count_r == FullCount);
    assign empty_o = (count_r == '0);
    assign data_o  = mem_r[rd_ptr_r];

    // Qualify requests so the pointers never overrun.
    always_comb begin
        push_s = push_i & ~full_o;
        pop_s  = pop_i & ~empty_o;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush_i) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (PtrWidth + 1)'(1);
                2'b01:   count_r <= count_r - (PtrWidth + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage, written on an accepted push.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= data_i;
        end
    end

endmodule

// File: rtl/rpc_rd_buffer_ctrl.sv
// Credit-based read-burst scheduler: a burst is only sent to the PHY once the
// SRAM read buffer has room for all of its words. Tracks in-flight bursts and
// gates the PHY-to-buffer write handshake; data words never pass through here.
module rpc_rd_buffer_ctrl
    import rpc_rd_buf_pkg::*;
#(
    parameter int unsigned DramLenWidth   = DefDramLenWidth,
    parameter int unsigned BufferDepth    = DefBufferDepth,
    parameter int unsigned MaxOutstanding = DefMaxOutstanding,
    parameter int unsigned DramAddrWidth  = DefDramAddrWidth,
    localparam int unsigned NumWords      = num_words(BufferDepth, DramLenWidth),
    localparam int unsigned AddrWidth     = $clog2(NumWords),
    localparam int unsigned CreditWidth   = credit_width(BufferDepth, DramLenWidth),
    localparam int unsigned OutWidth      = $clog2(MaxOutstanding + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [DramAddrWidth-1:0] req_addr_i,
    input  logic [DramLenWidth-1:0]  req_len_i,
    output logic                     cmd_valid_o,
    input  logic                     cmd_ready_i,
    output logic [DramAddrWidth-1:0] cmd_addr_o,
    output logic [DramLenWidth-1:0]  cmd_len_o,
    input  logic                     phy_valid_i,
    output logic                     phy_ready_o,
    output logic                     buf_w_valid_o,
    input  logic                     buf_w_ready_i,
    input  logic [AddrWidth:0]       buf_usage_i,
    output logic                     burst_done_o,
    output logic [OutWidth-1:0]      outstanding_o,
    output logic                     err_unexp_o
);

    state_e                   state_r;
    state_e                   state_s;
    logic                     req_ready_r;
    logic                     cmd_valid_r;
    logic [DramAddrWidth-1:0] addr_r;
    logic [DramLenWidth-1:0]  len_r;
    logic [AddrWidth:0]       pending_r;
    logic [AddrWidth:0]       pending_s;
    logic [OutWidth-1:0]      outstanding_r;
    logic [OutWidth-1:0]      outstanding_s;
    logic [DramLenWidth-1:0]  cnt_r;
    logic [DramLenWidth-1:0]  cnt_s;
    logic                     done_r;
    logic                     err_r;

    logic [CreditWidth-1:0]   free_raw_s;
    logic [AddrWidth:0]       free_s;
    logic [AddrWidth:0]       burst_words_s;
    logic                     can_issue_s;
    logic                     req_hs_s;
    logic                     cmd_hs_s;
    logic                     wr_hs_s;
    logic                     last_s;
    logic                     q_full_s;
    logic                     q_empty_s;
    logic [DramLenWidth-1:0]  head_len_s;

    // Lengths of issued bursts, oldest at the head; non-empty means a burst is active.
    fifo_v3 #(
        .DATA_WIDTH (DramLenWidth),
        .DEPTH      (MaxOutstanding)
    ) i_len_queue (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (1'b0),
        .full_o  (q_full_s),
        .empty_o (q_empty_s),
        .data_i  (len_r),
        .push_i  (cmd_hs_s),
        .data_o  (head_len_s),
        .pop_i   (last_s)
    );

    assign req_hs_s      = req_valid_i & req_ready_r;
    assign cmd_hs_s      = cmd_valid_r & cmd_ready_i;
    assign wr_hs_s       = phy_valid_i & buf_w_ready_i & ~q_empty_s;
    assign last_s        = wr_hs_s & (cnt_r == head_len_s);
    assign burst_words_s = (AddrWidth + 1)'(len_r) + (AddrWidth + 1)'(1);

    // Free space not yet promised to an in-flight burst; negative clamps to zero.
    always_comb begin
        free_raw_s = CreditWidth'(NumWords) - CreditWidth'(buf_usage_i) - CreditWidth'(pending_r);
        if (free_raw_s[CreditWidth-1]) begin
            free_s = '0;
        end else begin
            free_s = free_raw_s[AddrWidth:0];
        end
    end

    assign can_issue_s = (burst_words_s <= free_s) &&
                         (outstanding_r < OutWidth'(MaxOutstanding)) && !q_full_s;

    // Next-state logic for the request/credit/command sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_hs_s) begin
                    state_s = WAIT;
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                if (can_issue_s) begin
                    state_s = ISSUE;
                end else begin
                    state_s = WAIT;
                end
            end
            ISSUE: begin
                if (cmd_hs_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = ISSUE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Credit, in-flight and word-count updates; a command and a final word may coincide.
    always_comb begin
        pending_s     = pending_r;
        outstanding_s = outstanding_r;
        cnt_s         = cnt_r;
        if (cmd_hs_s) begin
            pending_s = pending_s + burst_words_s;
        end else begin
            pending_s = pending_s;
        end
        if (wr_hs_s) begin
            pending_s = pending_s - (AddrWidth + 1)'(1);
        end else begin
            pending_s = pending_s;
        end
        if (cmd_hs_s && !last_s) begin
            outstanding_s = outstanding_r + OutWidth'(1);
        end else if (!cmd_hs_s && last_s) begin
            outstanding_s = outstanding_r - OutWidth'(1);
        end else begin
            outstanding_s = outstanding_r;
        end
        if (last_s) begin
            cnt_s = '0;
        end else if (wr_hs_s) begin
            cnt_s = cnt_r + DramLenWidth'(1);
        end else begin
            cnt_s = cnt_r;
        end
    end

    // State register with outputs decoded from the next state so they leave flops.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r     <= IDLE;
            req_ready_r <= 1'b0;
            cmd_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            req_ready_r <= (state_s == IDLE);
            cmd_valid_r <= (state_s == ISSUE);
        end
    end

    // Request capture, counters and status flags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_r        <= '0;
            len_r         <= '0;
            pending_r     <= '0;
            outstanding_r <= '0;
            cnt_r         <= '0;
            done_r        <= 1'b0;
            err_r         <= 1'b0;
        end else begin
            if (req_hs_s) begin
                addr_r <= req_addr_i;
                len_r  <= req_len_i;
            end
            pending_r     <= pending_s;
            outstanding_r <= outstanding_s;
            cnt_r         <= cnt_s;
            done_r        <= last_s;
            err_r         <= err_r | (phy_valid_i & q_empty_s);
        end
    end

    assign req_ready_o   = req_ready_r;
    assign cmd_valid_o   = cmd_valid_r;
    assign cmd_addr_o    = addr_r;
    assign cmd_len_o     = len_r;
    assign phy_ready_o   = buf_w_ready_i & ~q_empty_s;
    assign buf_w_valid_o = phy_valid_i & ~q_empty_s;
    assign burst_done_o  = done_r;
    assign outstanding_o = outstanding_r;
    assign err_unexp_o   = err_r;

endmodule
